sys_ctrl_burst: RTL and testbench

- Parametrised next-generation command controller in the REF_CLK domain.
- Parses byte commands arriving from the RX data synchroniser.
- Drives the register file, ALU and clock gate, and serialises responses into the TX async FIFO.
- Adds burst read/write, a configurable ALU result width, and error/abort handling.

---
 rtl/sys_ctrl_burst.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_sys_ctrl_burst.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_burst.sv
// ---------------------------------------------------------------------------
// sys_ctrl_burst : REF_CLK-domain command controller.
//
// Parses byte commands from the RX synchroniser, drives the register file,
// the ALU and its clock gate, and serialises responses into the TX FIFO.
// Supports single and burst register access, ALU ops with a multi-byte
// result, and error/abort handling (UART errors, bad opcode, bad length).
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   RX_P_DATA/RX_D_VLD       incoming byte and its one-cycle strobe
//   PAR_ERR/FRM_ERR          UART error levels qualifying RX_D_VLD
//   ALU_OUT/ALU_OUT_VLD      ALU result and valid pulse
//   RdData/RdData_Valid      register-file read return
//   FIFO_FULL                TX FIFO back-pressure
//   ALU_FUN/ALU_EN/CLK_EN    ALU function, start pulse, clock-gate enable
//   Address/WrEn/RdEn/WrData register-file access
//   TX_P_DATA/TX_D_VLD       TX FIFO write port
//   CLK_DIV_EN               UART clock divider enable (always on)
//   CMD_ERR                  one-cycle error pulse
//   BUSY                     high whenever the FSM is not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module sys_ctrl_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ALU_BYTES  = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [DATA_WIDTH-1:0]           RX_P_DATA,
    input  logic                            RX_D_VLD,
    input  logic                            PAR_ERR,
    input  logic                            FRM_ERR,
    input  logic [ALU_BYTES*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                            ALU_OUT_VLD,
    input  logic [DATA_WIDTH-1:0]           RdData,
    input  logic                            RdData_Valid,
    input  logic                            FIFO_FULL,
    output logic [3:0]                      ALU_FUN,
    output logic                            ALU_EN,
    output logic                            CLK_EN,
    output logic [ADDR_WIDTH-1:0]           Address,
    output logic                            WrEn,
    output logic                            RdEn,
    output logic [DATA_WIDTH-1:0]           WrData,
    output logic [DATA_WIDTH-1:0]           TX_P_DATA,
    output logic                            TX_D_VLD,
    output logic                            CLK_DIV_EN,
    output logic                            CMD_ERR,
    output logic                            BUSY
);

    // Byte counter must hold a burst length and also index the ALU result bytes.
    localparam int CNT_A = $clog2(MAX_BURST + 1);
    localparam int CNT_B = (ALU_BYTES > 1) ? $clog2(ALU_BYTES) : 1;
    localparam int CNT_W = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int RES_W = ALU_BYTES * DATA_WIDTH;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GET_ADDR  = 4'd1;
    localparam logic [3:0] S_GET_DATA  = 4'd2;
    localparam logic [3:0] S_GET_LEN   = 4'd3;
    localparam logic [3:0] S_GET_A     = 4'd4;
    localparam logic [3:0] S_GET_B     = 4'd5;
    localparam logic [3:0] S_GET_FUN   = 4'd6;
    localparam logic [3:0] S_RF_WR     = 4'd7;
    localparam logic [3:0] S_RF_RD     = 4'd8;
    localparam logic [3:0] S_RD_WAIT   = 4'd9;
    localparam logic [3:0] S_ALU_START = 4'd10;
    localparam logic [3:0] S_ALU_WAIT  = 4'd11;
    localparam logic [3:0] S_TX_PUSH   = 4'd12;

    localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_WR = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] OP_BWR    = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] OP_BRD    = DATA_WIDTH'(8'hEF);

    logic [3:0]            r_state,     w_state_nxt;
    logic [DATA_WIDTH-1:0] r_op,        w_op_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_a,         w_a_nxt;
    logic [DATA_WIDTH-1:0] r_b,         w_b_nxt;
    logic [3:0]            r_fun,       w_fun_nxt;
    logic [DATA_WIDTH-1:0] r_rd_byte,   w_rd_byte_nxt;
    logic [RES_W-1:0]      r_alu_res,   w_alu_res_nxt;
    logic [3:0]            r_alu_fun,   w_alu_fun_nxt;
    logic                  r_alu_en,    w_alu_en_nxt;
    logic                  r_clk_en,    w_clk_en_nxt;
    logic [ADDR_WIDTH-1:0] r_address,   w_address_nxt;
    logic                  r_wr_en,     w_wr_en_nxt;
    logic                  r_rd_en,     w_rd_en_nxt;
    logic [DATA_WIDTH-1:0] r_wr_data,   w_wr_data_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data,   w_tx_data_nxt;
    logic                  r_tx_vld,    w_tx_vld_nxt;
    logic                  r_cmd_err,   w_cmd_err_nxt;
    logic                  r_busy;
    logic                  r_clk_div_en;

    logic                  w_collecting;
    logic                  w_uart_err;
    logic                  w_len_bad;
    logic                  w_is_alu_op;
    logic [DATA_WIDTH-1:0] w_alu_byte;
    logic [DATA_WIDTH-1:0] w_push_byte;

    assign w_uart_err  = PAR_ERR | FRM_ERR;
    assign w_len_bad   = (RX_P_DATA == {DATA_WIDTH{1'b0}}) ||
                         (RX_P_DATA > DATA_WIDTH'(MAX_BURST));
    assign w_is_alu_op = (r_op == OP_ALU_WR) || (r_op == OP_ALU);
    assign w_push_byte = w_is_alu_op ? w_alu_byte : r_rd_byte;

    // States in which an RX byte is consumed; elsewhere bytes are dropped silently.
    always_comb begin
        case (r_state)
            S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_LEN,
            S_GET_A, S_GET_B, S_GET_FUN: w_collecting = 1'b1;
            default:                     w_collecting = 1'b0;
        endcase
    end

    // Select the ALU result byte addressed by the byte counter (LSB first).
    always_comb begin
        w_alu_byte = r_alu_res[DATA_WIDTH-1:0];
        for (int i = 0; i < ALU_BYTES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_alu_byte = r_alu_res[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_alu_byte = w_alu_byte;
            end
        end
    end

    // Next-state and next-output logic of the command FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_fun_nxt     = r_fun;
        w_rd_byte_nxt = r_rd_byte;
        w_alu_res_nxt = r_alu_res;
        w_alu_fun_nxt = r_alu_fun;
        w_clk_en_nxt  = r_clk_en;
        w_address_nxt = r_address;
        w_wr_data_nxt = r_wr_data;
        w_tx_data_nxt = r_tx_data;
        w_alu_en_nxt  = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_tx_vld_nxt  = 1'b0;
        w_cmd_err_nxt = 1'b0;

        if (w_collecting && RX_D_VLD && w_uart_err) begin
            // A corrupted byte aborts whatever command was being collected.
            w_cmd_err_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        w_op_nxt  = RX_P_DATA;
                        w_cnt_nxt = {CNT_W{1'b0}};
                        case (RX_P_DATA)
                            OP_WR, OP_RD, OP_BWR, OP_BRD: w_state_nxt = S_GET_ADDR;
                            OP_ALU_WR:                    w_state_nxt = S_GET_A;
                            OP_ALU:                       w_state_nxt = S_GET_FUN;
                            default:                      w_cmd_err_nxt = 1'b1;
                        endcase
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_GET_ADDR: begin
                    if (RX_D_VLD) begin
                        w_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                        if (r_op == OP_RD) begin
                            w_address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                            w_rd_en_nxt   = 1'b1;
                            w_state_nxt   = S_RF_RD;
                        end else if (r_op == OP_WR) begin
                            w_state_nxt = S_GET_DATA;
                        end else begin
                            w_state_nxt = S_GET_LEN;
                        end
                    end else begin
                        w_state_nxt = S_GET_ADDR;
                    end
                end
                S_GET_LEN: begin
                    if (RX_D_VLD) begin
                        if (w_len_bad) begin
                            w_cmd_err_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end else if (r_op == OP_BWR) begin
                            w_cnt_nxt   = CNT_W'(RX_P_DATA);
                            w_state_nxt = S_GET_DATA;
                        end else begin
                            w_cnt_nxt     = CNT_W'(RX_P_DATA);
                            w_address_nxt = r_addr;
                            w_rd_en_nxt   = 1'b1;
                            w_state_nxt   = S_RF_RD;
                        end
                    end else begin
                        w_state_nxt = S_GET_LEN;
                    end
                end
                S_GET_DATA: begin
                    if (RX_D_VLD) begin
                        w_wr_en_nxt   = 1'b1;
                        w_address_nxt = r_addr;
                        w_wr_data_nxt = RX_P_DATA;
                        // Address wraps naturally at 2^ADDR_WIDTH.
                        w_addr_nxt    = r_addr + ADDR_WIDTH'(1);
                        w_state_nxt   = S_RF_WR;
                        if (r_op == OP_BWR) begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end else begin
                            w_cnt_nxt = r_cnt;
                        end
                    end else begin
                        w_state_nxt = S_GET_DATA;
                    end
                end
                S_GET_A: begin
                    if (RX_D_VLD) begin
                        w_a_nxt     = RX_P_DATA;
                        w_state_nxt = S_GET_B;
                    end else begin
                        w_state_nxt = S_GET_A;
                    end
                end
                S_GET_B: begin
                    if (RX_D_VLD) begin
                        w_b_nxt     = RX_P_DATA;
                        w_state_nxt = S_GET_FUN;
                    end else begin
                        w_state_nxt = S_GET_B;
                    end
                end
                S_GET_FUN: begin
                    if (RX_D_VLD) begin
                        w_fun_nxt = RX_P_DATA[3:0];
                        if (r_op == OP_ALU_WR) begin
                            // Operand A first; r_cnt=1 marks that B is still owed.
                            w_wr_en_nxt   = 1'b1;
                            w_address_nxt = {ADDR_WIDTH{1'b0}};
                            w_wr_data_nxt = r_a;
                            w_cnt_nxt     = CNT_W'(1);
                            w_state_nxt   = S_RF_WR;
                        end else begin
                            w_alu_en_nxt  = 1'b1;
                            w_clk_en_nxt  = 1'b1;
                            w_alu_fun_nxt = RX_P_DATA[3:0];
                            w_cnt_nxt     = {CNT_W{1'b0}};
                            w_state_nxt   = S_ALU_START;
                        end
                    end else begin
                        w_state_nxt = S_GET_FUN;
                    end
                end
                S_RF_WR: begin
                    if (r_op == OP_ALU_WR) begin
                        if (r_cnt != {CNT_W{1'b0}}) begin
                            w_wr_en_nxt   = 1'b1;
                            w_address_nxt = ADDR_WIDTH'(1);
                            w_wr_data_nxt = r_b;
                            w_cnt_nxt     = {CNT_W{1'b0}};
                            w_state_nxt   = S_RF_WR;
                        end else begin
                            w_alu_en_nxt  = 1'b1;
                            w_clk_en_nxt  = 1'b1;
                            w_alu_fun_nxt = r_fun;
                            w_state_nxt   = S_ALU_START;
                        end
                    end else if ((r_op == OP_BWR) && (r_cnt != {CNT_W{1'b0}})) begin
                        w_state_nxt = S_GET_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RF_RD: begin
                    w_state_nxt = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (RdData_Valid) begin
                        w_rd_byte_nxt = RdData;
                        w_state_nxt   = S_TX_PUSH;
                    end else begin
                        w_state_nxt = S_RD_WAIT;
                    end
                end
                S_ALU_START: begin
                    w_state_nxt = S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        w_alu_res_nxt = ALU_OUT;
                        w_clk_en_nxt  = 1'b0;
                        w_cnt_nxt     = {CNT_W{1'b0}};
                        w_state_nxt   = S_TX_PUSH;
                    end else begin
                        w_state_nxt = S_ALU_WAIT;
                    end
                end
                S_TX_PUSH: begin
                    // Data and strobe are updated together, so TX_P_DATA holds while stalled.
                    if (!FIFO_FULL) begin
                        w_tx_vld_nxt  = 1'b1;
                        w_tx_data_nxt = w_push_byte;
                        if (w_is_alu_op) begin
                            if (r_cnt == CNT_W'(ALU_BYTES - 1)) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_cnt_nxt   = r_cnt + CNT_W'(1);
                                w_state_nxt = S_TX_PUSH;
                            end
                        end else if ((r_op == OP_BRD) && (r_cnt > CNT_W'(1))) begin
                            w_cnt_nxt     = r_cnt - CNT_W'(1);
                            w_addr_nxt    = r_addr + ADDR_WIDTH'(1);
                            w_address_nxt = r_addr + ADDR_WIDTH'(1);
                            w_rd_en_nxt   = 1'b1;
                            w_state_nxt   = S_RF_RD;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_TX_PUSH;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset drops any command in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_op         <= {DATA_WIDTH{1'b0}};
            r_addr       <= {ADDR_WIDTH{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_a          <= {DATA_WIDTH{1'b0}};
            r_b          <= {DATA_WIDTH{1'b0}};
            r_fun        <= 4'd0;
            r_rd_byte    <= {DATA_WIDTH{1'b0}};
            r_alu_res    <= {RES_W{1'b0}};
            r_alu_fun    <= 4'd0;
            r_alu_en     <= 1'b0;
            r_clk_en     <= 1'b0;
            r_address    <= {ADDR_WIDTH{1'b0}};
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wr_data    <= {DATA_WIDTH{1'b0}};
            r_tx_data    <= {DATA_WIDTH{1'b0}};
            r_tx_vld     <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_clk_div_en <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_addr       <= w_addr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_fun        <= w_fun_nxt;
            r_rd_byte    <= w_rd_byte_nxt;
            r_alu_res    <= w_alu_res_nxt;
            r_alu_fun    <= w_alu_fun_nxt;
            r_alu_en     <= w_alu_en_nxt;
            r_clk_en     <= w_clk_en_nxt;
            r_address    <= w_address_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_vld     <= w_tx_vld_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_clk_div_en <= 1'b1;
        end
    end

    assign ALU_FUN    = r_alu_fun;
    assign ALU_EN     = r_alu_en;
    assign CLK_EN     = r_clk_en;
    assign Address    = r_address;
    assign WrEn       = r_wr_en;
    assign RdEn       = r_rd_en;
    assign WrData     = r_wr_data;
    assign TX_P_DATA  = r_tx_data;
    assign TX_D_VLD   = r_tx_vld;
    assign CLK_DIV_EN = r_clk_div_en;
    assign CMD_ERR    = r_cmd_err;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// ---------------------------------------------------------------------------
// tb_sys_ctrl_burst : table-driven bench for sys_ctrl_burst.
// Each table row is one command (bytes plus per-byte UART error flags) with
// the register writes, reads, TX bytes, error pulses and ALU starts it must
// produce. A register-file model and an ALU responder answer the DUT.
// ---------------------------------------------------------------------------
module tb_sys_ctrl_burst;

    logic        clk;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        PAR_ERR;
    logic        FRM_ERR;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic        FIFO_FULL;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic        CLK_EN;
    logic [3:0]  Address;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  WrData;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CLK_DIV_EN;
    logic        CMD_ERR;
    logic        BUSY;

    sys_ctrl_burst dut (
        .CLK(clk), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .RdData(RdData), .RdData_Valid(RdData_Valid),
        .FIFO_FULL(FIFO_FULL), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CLK_DIV_EN(CLK_DIV_EN),
        .CMD_ERR(CMD_ERR), .BUSY(BUSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          n;       // number of command bytes
        logic [47:0] b;       // byte i at [8*i +: 8]
        logic [5:0]  perr;    // PAR_ERR per byte
        logic [5:0]  ferr;    // FRM_ERR per byte
        logic [15:0] alu;     // ALU result returned
        int          n_wr;
        logic [47:0] wr;      // write i at [12*i +: 12] = {addr, data}
        int          n_tx;
        logic [31:0] tx;      // TX byte i at [8*i +: 8]
        int          n_err;
        int          n_rd;
        int          n_alu;
        logic [3:0]  fun;
    } vec_t;

    int tests  = 0;
    int failed = 0;

    // Monitor logs (cumulative; each check works on deltas)
    logic [11:0] wr_log [64];
    logic [7:0]  tx_log [64];
    logic [7:0]  mem    [16];
    int wr_n = 0, tx_n = 0, err_n = 0, rd_n = 0, alu_n = 0, clken_n = 0, tx_full_n = 0;
    logic [3:0]  alu_fun_l = 4'd0;
    logic [15:0] cur_alu = 16'd0;
    int rd_cd = 0, alu_cd = 0;
    logic [3:0] rd_addr_l = 4'd0;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor + register-file model + ALU responder, all on the falling edge.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        RdData = 8'h00; RdData_Valid = 1'b0; ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0;
        forever begin
            @(negedge clk);
            RdData_Valid = 1'b0;
            ALU_OUT_VLD  = 1'b0;
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    RdData = mem[rd_addr_l];
                    RdData_Valid = 1'b1;
                end
            end
            if (alu_cd > 0) begin
                alu_cd--;
                if (alu_cd == 0) begin
                    ALU_OUT = cur_alu;
                    ALU_OUT_VLD = 1'b1;
                end
            end
            if (WrEn) begin
                mem[Address] = WrData;
                wr_log[wr_n % 64] = {Address, WrData};
                wr_n++;
            end
            if (RdEn) begin
                rd_n++;
                rd_cd = 2;
                rd_addr_l = Address;
            end
            if (ALU_EN) begin
                alu_n++;
                alu_fun_l = ALU_FUN;
                alu_cd = 3;
            end
            if (CLK_EN) clken_n++;
            if (CMD_ERR) err_n++;
            if (TX_D_VLD) begin
                tx_log[tx_n % 64] = TX_P_DATA;
                tx_n++;
                if (FIFO_FULL) tx_full_n++;
            end
        end
    end

    function automatic vec_t mk(input int n, input logic [47:0] b, input logic [5:0] pe,
                                input logic [5:0] fe, input logic [15:0] alu,
                                input int n_wr, input logic [47:0] wr,
                                input int n_tx, input logic [31:0] tx,
                                input int n_err, input int n_rd, input int n_alu,
                                input logic [3:0] fun);
        vec_t v;
        v.n = n; v.b = b; v.perr = pe; v.ferr = fe; v.alu = alu;
        v.n_wr = n_wr; v.wr = wr; v.n_tx = n_tx; v.tx = tx;
        v.n_err = n_err; v.n_rd = n_rd; v.n_alu = n_alu; v.fun = fun;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe);
        @(negedge clk);
        RX_P_DATA = d; RX_D_VLD = 1'b1; PAR_ERR = pe; FRM_ERR = fe;
        @(negedge clk);
        RX_D_VLD = 1'b0; PAR_ERR = 1'b0; FRM_ERR = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input int idx);
        int cnt;
        cnt = 0;
        while (BUSY && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("idle_timeout", idx, 64'(cnt >= 300), 64'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wr_b, tx_b, err_b, rd_b, alu_b, ck_b;
        logic [47:0] act_wr;
        logic [31:0] act_tx;
        wr_b = wr_n; tx_b = tx_n; err_b = err_n; rd_b = rd_n; alu_b = alu_n; ck_b = clken_n;
        cur_alu = v.alu;
        for (int i = 0; i < v.n; i++) send_byte(v.b[8*i +: 8], v.perr[i], v.ferr[i]);
        wait_idle(idx);
        act_wr = '0;
        for (int j = 0; j < 4; j++)
            if (j < wr_n - wr_b) act_wr[12*j +: 12] = wr_log[(wr_b + j) % 64];
        act_tx = '0;
        for (int j = 0; j < 4; j++)
            if (j < tx_n - tx_b) act_tx[8*j +: 8] = tx_log[(tx_b + j) % 64];
        chk("wr_count", idx, 64'(wr_n - wr_b), 64'(v.n_wr));
        chk("wr_list",  idx, 64'(act_wr), 64'(v.wr));
        chk("tx_count", idx, 64'(tx_n - tx_b), 64'(v.n_tx));
        chk("tx_bytes", idx, 64'(act_tx), 64'(v.tx));
        chk("cmd_err",  idx, 64'(err_n - err_b), 64'(v.n_err));
        chk("rd_count", idx, 64'(rd_n - rd_b), 64'(v.n_rd));
        chk("alu_en",   idx, 64'(alu_n - alu_b), 64'(v.n_alu));
        chk("clk_en_cycles", idx, 64'(clken_n - ck_b), 64'(4 * v.n_alu));
        chk("busy_end", idx, 64'(BUSY), 64'd0);
        if (v.n_alu != 0) chk("alu_fun", idx, 64'(alu_fun_l), 64'(v.fun));
    endtask

    vec_t vecs [14];

    initial begin
        int tx_b, rd_b;
        vecs[0]  = mk(3, 48'h3C05AA,       6'b0, 6'b0, 16'h0000, 1, 48'h53C,       0, 32'h0,      0, 0, 0, 4'd0);
        vecs[1]  = mk(4, 48'h000307CC,     6'b0, 6'b0, 16'h000A, 2, 48'h103007,    2, 32'h000A,   0, 0, 1, 4'd0);
        vecs[2]  = mk(6, 48'h332211030EEE, 6'b0, 6'b0, 16'h0000, 3, 48'h033F22E11, 0, 32'h0,      0, 0, 0, 4'd0);
        vecs[3]  = mk(3, 48'h030EEF,       6'b0, 6'b0, 16'h0000, 0, 48'h0,         3, 32'h332211, 0, 3, 0, 4'd0);
        vecs[4]  = mk(3, 48'h0000EE,       6'b0, 6'b0, 16'h0000, 0, 48'h0,         0, 32'h0,      1, 0, 0, 4'd0);
        vecs[5]  = mk(1, 48'h55,           6'b0, 6'b0, 16'h0000, 0, 48'h0,         0, 32'h0,      1, 0, 0, 4'd0);
        vecs[6]  = mk(3, 48'h0900EE,       6'b0, 6'b0, 16'h0000, 0, 48'h0,         0, 32'h0,      1, 0, 0, 4'd0);
        vecs[7]  = mk(2, 48'h13DD,         6'b0, 6'b0, 16'hBEEF, 0, 48'h0,         2, 32'hBEEF,   0, 0, 1, 4'd3);
        vecs[8]  = mk(2, 48'h01BB,         6'b0, 6'b0, 16'h0000, 0, 48'h0,         1, 32'h03,     0, 1, 0, 4'd0);
        vecs[9]  = mk(3, 48'h020FEF,       6'b0, 6'b0, 16'h0000, 0, 48'h0,         2, 32'h3322,   0, 2, 0, 4'd0);
        vecs[10] = mk(3, 48'h4402AA, 6'b000100, 6'b0, 16'h0000, 0, 48'h0,         0, 32'h0,      1, 0, 0, 4'd0);
        vecs[11] = mk(3, 48'h4402AA,       6'b0, 6'b0, 16'h0000, 1, 48'h244,       0, 32'h0,      0, 0, 0, 4'd0);
        vecs[12] = mk(2, 48'h05BB,   6'b0, 6'b000010, 16'h0000, 0, 48'h0,         0, 32'h0,      1, 0, 0, 4'd0);
        vecs[13] = mk(2, 48'h02BB,         6'b0, 6'b0, 16'h0000, 0, 48'h0,         1, 32'h44,     0, 1, 0, 4'd0);

        RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; PAR_ERR = 1'b0; FRM_ERR = 1'b0;
        FIFO_FULL = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulses", 0, 64'({WrEn, RdEn, TX_D_VLD, CMD_ERR, ALU_EN, CLK_EN, BUSY}), 64'd0);
        chk("rst_clk_div_en", 0, 64'(CLK_DIV_EN), 64'd1);
        chk("rst_data", 0, 64'({TX_P_DATA, WrData, Address, ALU_FUN}), 64'd0);
        RST = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 14; k++) run_vec(vecs[k], k);

        // Read with FIFO_FULL held high for 10 cycles after the command.
        tx_b = tx_n;
        FIFO_FULL = 1'b1;
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("full_no_tx", 100, 64'(tx_n - tx_b), 64'd0);
        chk("full_busy", 100, 64'(BUSY), 64'd1);
        FIFO_FULL = 1'b0;
        wait_idle(100);
        chk("full_tx_count", 100, 64'(tx_n - tx_b), 64'd1);
        chk("full_tx_data", 100, 64'(tx_log[tx_b % 64]), 64'h3C);
        chk("tx_while_full", 100, 64'(tx_full_n), 64'd0);

        // Reset in the middle of a stalled burst read.
        FIFO_FULL = 1'b1;
        send_byte(8'hEF, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("midrst_busy", 101, 64'(BUSY), 64'd1);
        RST = 1'b1;
        @(negedge clk);
        tx_b = tx_n; rd_b = rd_n;
        chk("midrst_pulses", 101, 64'({WrEn, RdEn, TX_D_VLD, CMD_ERR, ALU_EN, CLK_EN, BUSY}), 64'd0);
        chk("midrst_vals", 101, 64'({CLK_DIV_EN, TX_P_DATA, Address}), 64'h1000);
        @(negedge clk);
        RST = 1'b0;
        FIFO_FULL = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_tx", 101, 64'(tx_n - tx_b), 64'd0);
        chk("midrst_no_rd", 101, 64'(rd_n - rd_b), 64'd0);
        run_vec(mk(3, 48'h5A03AA, 6'b0, 6'b0, 16'h0000, 1, 48'h35A, 0, 32'h0, 0, 0, 0, 4'd0), 102);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
